// File: rtl/rom_loader.sv
// Streams HPS ioctl download bytes into SDRAM through a toggle write handshake,
// tracking the cart address mask, byte count and overflow. Optional: ROM_LOADER_CHKSUM_EN.
module rom_loader #(
    parameter int GG_INDEX = 2,
    parameter int MASK_W   = 22
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [23:0]       mem_waddr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic              mem_we_ack,
    output logic [MASK_W-1:0] cart_mask,
    output logic              gg,
    output logic              busy,
    output logic              ovf,
`ifdef ROM_LOADER_CHKSUM_EN
    output logic [15:0]       chksum,
`endif
    output logic [24:0]       rom_bytes
);

    typedef enum logic [1:0] {IDLE, ARM, PEND, FLUSH} state_t;

    state_t            state, state_nx;
    logic              dl_q, rise, fall, match;
    logic              held, restart, want_restart;
    logic              start, issue, hold, ack, drop, stop;
    logic [MASK_W-1:0] held_mask;
    logic              unused_bits;

    assign unused_bits  = ^{ioctl_index[7:5], ioctl_addr};
    assign rise         = ioctl_download & ~dl_q;
    assign fall         = ~ioctl_download & dl_q;
    assign match        = (mem_we == mem_we_ack);
    // A restart seen during a pending write is honoured only if the line is still high.
    assign want_restart = (restart | rise) & ~fall;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        issue    = 1'b0;
        hold     = 1'b0;
        ack      = 1'b0;
        drop     = 1'b0;
        stop     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    start    = 1'b1;
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    start = 1'b1;
                end else if (fall) begin
                    stop     = 1'b1;
                    state_nx = IDLE;
                end else if ((ioctl_wr || held) && match) begin
                    issue    = 1'b1;
                    state_nx = PEND;
                end else if (ioctl_wr) begin
                    hold = 1'b1;
                end
            end
            PEND, FLUSH: begin
                drop = ioctl_wr;
                if (match) begin
                    ack = 1'b1;
                    if (want_restart) begin
                        start    = 1'b1;
                        state_nx = ARM;
                    end else if (fall || state == FLUSH) begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = ARM;
                    end
                end else if (fall) begin
                    state_nx = FLUSH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The toggle is never reset so it stays paired with the controller's ack.
    always_ff @(posedge clk_sys) begin
        if (!reset && issue) mem_we <= ~mem_we;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            restart    <= 1'b0;
            held       <= 1'b0;
            held_mask  <= '0;
            ioctl_wait <= 1'b0;
            mem_waddr  <= '0;
            mem_din    <= '0;
            cart_mask  <= '0;
            gg         <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            rom_bytes  <= '0;
`ifdef ROM_LOADER_CHKSUM_EN
            chksum     <= '0;
`endif
        end else begin
            dl_q <= ioctl_download;
            if (rise && (state == PEND || state == FLUSH)) restart <= 1'b1;
            else if (fall)                                 restart <= 1'b0;

            if (ack) begin
                ioctl_wait <= 1'b0;
                mem_waddr  <= mem_waddr + 24'd1;
                if (mem_waddr == '1) ovf <= 1'b1;
                if (rom_bytes != '1) rom_bytes <= rom_bytes + 25'd1;
`ifdef ROM_LOADER_CHKSUM_EN
                chksum     <= chksum + {8'd0, mem_din};
`endif
            end
            if (issue) begin
                ioctl_wait <= 1'b1;
                held       <= 1'b0;
                cart_mask  <= cart_mask | (held ? held_mask : ioctl_addr[MASK_W-1:0]);
                if (!held) mem_din <= ioctl_dout;
            end
            if (hold) begin
                ioctl_wait <= 1'b1;
                held       <= 1'b1;
                held_mask  <= ioctl_addr[MASK_W-1:0];
                mem_din    <= ioctl_dout;
            end
            if (drop) ovf <= 1'b1;
            if (stop) begin
                busy       <= 1'b0;
                ioctl_wait <= 1'b0;
                held       <= 1'b0;
            end
            if (start) begin
                restart    <= 1'b0;
                held       <= 1'b0;
                ioctl_wait <= 1'b0;
                mem_waddr  <= '0;
                cart_mask  <= '0;
                rom_bytes  <= '0;
                ovf        <= 1'b0;
                busy       <= 1'b1;
                gg         <= (ioctl_index[4:0] == GG_INDEX[4:0]);
`ifdef ROM_LOADER_CHKSUM_EN
                chksum     <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter GG_INDEX, default 2: ioctl_index[4:0] value that marks a Game Gear image.
REQ-002 Parameter MASK_W, default 22: width of cart_mask and of the mask accumulation.
REQ-003 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  high while the HPS streams a file.
REQ-006 ioctl_index  in  8  file index of the current download.
REQ-007 ioctl_wr  in  1  single-cycle strobe; a byte is valid on ioctl_dout/ioctl_addr.
REQ-008 ioctl_addr  in  25  byte offset in the file.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_wait  out  1  back-pressure to the HPS; high while a byte is pending.
REQ-011 mem_waddr  out  24  SDRAM write byte address.
REQ-012 mem_din  out  8  SDRAM write data.
REQ-013 mem_we  out  1  toggle request: each level change is one write.
REQ-014 mem_we_ack  in  1  toggle acknowledge from the SDRAM controller.
REQ-015 cart_mask  out  MASK_W  OR of all written ioctl_addr[MASK_W-1:0] values, used as the read-address mask.
REQ-016 gg  out  1  high if the last download used index GG_INDEX.
REQ-017 busy  out  1  high from the start of a download until its last write is acknowledged.
REQ-018 ovf  out  1  sticky flag: a strobe was dropped or mem_waddr wrapped.
REQ-019 rom_bytes  out  25  count of acknowledged bytes, saturating at all-ones.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ARM, PEND and FLUSH.
REQ-021 IDLE: on a 0->1 edge of ioctl_download, go to ARM in the next cycle.
- Clear mem_waddr, cart_mask, rom_bytes and ovf; set busy.
- gg <= (ioctl_index[4:0] == GG_INDEX).
REQ-022 ARM: when ioctl_wr is high and mem_we == mem_we_ack, go to PEND in the same edge.
- Latch mem_din <= ioctl_dout; toggle mem_we; set ioctl_wait <= 1.
- cart_mask <= cart_mask | ioctl_addr[MASK_W-1:0].
REQ-023 ARM: if ioctl_wr is high while mem_we != mem_we_ack (stale request after reset), hold the byte, raise ioctl_wait, and issue the write in the first cycle the toggles match.
REQ-024 PEND: when mem_we == mem_we_ack, clear ioctl_wait, increment mem_waddr and rom_bytes, and return to ARM.
- Acknowledge-to-ioctl_wait-low latency is one clock.
REQ-025 PEND: an ioctl_wr strobe SHALL be dropped and SHALL set ovf; no second toggle is issued.
REQ-026 mem_waddr SHALL wrap from 0xFFFFFF to 0 and set ovf; rom_bytes SHALL saturate.
REQ-027 A 1->0 edge of ioctl_download in ARM goes to IDLE and clears busy.
REQ-028 A 1->0 edge of ioctl_download in PEND goes to FLUSH.
- FLUSH completes the pending acknowledge exactly as PEND does, then goes to IDLE and clears busy.
REQ-029 A 0->1 edge of ioctl_download in any state other than IDLE SHALL restart the download as in REQ-021 after the pending acknowledge, if any.
REQ-030 mem_waddr SHALL be stable from the mem_we toggle until the matching acknowledge.
REQ-031 cart_mask, gg and rom_bytes SHALL hold their values after a download ends, until the next download starts.

Reset
REQ-032 reset SHALL force the state to IDLE, ioctl_wait=0, busy=0, ovf=0, mem_waddr=0, mem_din=0, rom_bytes=0, cart_mask=0 and gg=0.
REQ-033 mem_we SHALL NOT be changed by reset, so the toggle pair stays consistent with the SDRAM controller.
REQ-034 A reset during PEND abandons the byte; a later request waits for toggle match per REQ-023.
REQ-035 reset has priority over all other events in the same cycle.

Configuration
REQ-036 Macro ROM_LOADER_CHKSUM_EN.
- When defined: add output chksum [15:0], cleared at download start and on reset. On each acknowledge, chksum <= chksum + mem_din, modulo 2^16.
- When undefined: no chksum port, and logic is identical otherwise.

Verification
REQ-037 Download 4 bytes at addr 0..3, index 1, with ack 2 cycles after each toggle -> mem_waddr 0..3 written, ioctl_wait high 3 cycles per byte, rom_bytes=4, cart_mask=0x3, gg=0, busy low after the 4th ack.
REQ-038 Download with index 0x42 (GG) writing addr 0x3FFF only -> gg=1, cart_mask=0x3FFF.
REQ-039 Second ioctl_wr while in PEND -> exactly one toggle, ovf=1, data of the first byte written.
REQ-040 Drop ioctl_download while a write is pending, with ack 5 cycles later -> FLUSH, busy clears the cycle after the ack, mem_waddr=1.
REQ-041 Assert reset in PEND, then start a new download with the ack arriving late -> the first new toggle is issued only after mem_we == mem_we_ack, and ioctl_wait stays high until then.
REQ-042 With ROM_LOADER_CHKSUM_EN, bytes 0xFF,0x01,0x10 -> chksum=0x0110.
